// File: rtl/object_scanline_loader.sv
// -----------------------------------------------------------------------------
// object_scanline_loader
//
// Sequencer that builds one object scanline. On every line request it clears
// the scanline buffer, then walks the OBM from index 63 down to 0, issuing one
// load per object that covers the requested line. Lower indices are loaded
// later, so object 0 ends up drawn on top. Pattern-memory lightness for the
// pixel the buffer is currently drawing is relayed straight through.
//
// Ports
//   gpu_clk, rst_n              clock, asynchronous active-low reset
//   start_i, y_i                line request pulse and target line
//   busy_o, done_o              build in progress / build finished (level)
//   obm_index_o, obm_object_i   OBM read index and combinational read data
//   scan_ready_i                buffer idle
//   scan_clear_start_o          buffer clear request
//   scan_new_y_o                registered target line
//   scan_load_start_o           buffer load request
//   scan_load_object_o          object being loaded (held for the whole load)
//   scan_load_intx_i/_inty_i    pattern coordinates requested by the buffer
//   pmf_object_o, pmf_intx_o,
//   pmf_inty_o                  pattern fetch request (pass-through)
//   pmf_lightness_i             pattern lightness from the fetch unit
//   scan_load_lightness_o       lightness relayed to the buffer
// -----------------------------------------------------------------------------
package obm_pkg;
    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
        logic [5:0] pattern;
        logic [1:0] color;
    } obm_object_t;
endpackage

module object_scanline_loader
    import obm_pkg::*;
(
    input  logic        gpu_clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  y_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [5:0]  obm_index_o,
    input  obm_object_t obm_object_i,
    input  logic        scan_ready_i,
    output logic        scan_clear_start_o,
    output logic [7:0]  scan_new_y_o,
    output logic        scan_load_start_o,
    output obm_object_t scan_load_object_o,
    input  logic [2:0]  scan_load_intx_i,
    input  logic [2:0]  scan_load_inty_i,
    output obm_object_t pmf_object_o,
    output logic [2:0]  pmf_intx_o,
    output logic [2:0]  pmf_inty_o,
    input  logic [1:0]  pmf_lightness_i,
    output logic [1:0]  scan_load_lightness_o
);

    typedef enum logic [2:0] {
        IDLE, CLEAR_REQ, CLEAR_WAIT, SCAN, LOAD_REQ, LOAD_WAIT, DONE
    } state_t;

    state_t      state, state_n;
    logic [7:0]  line, line_n;
    obm_object_t obj, obj_n;
    logic [5:0]  index, index_n;
    logic        settled, settled_n;   // CLEAR_WAIT has passed its first cycle
    logic        busy, busy_n;
    logic        done, done_n;

    // 9-bit compare so objects near the bottom edge never wrap onto line 0.
    logic [8:0] line_ext, obj_top_ext;
    logic       hit;

    assign line_ext    = {1'b0, line};
    assign obj_top_ext = {1'b0, obm_object_i.y} + 9'd7;
    assign hit         = (line_ext >= {1'b0, obm_object_i.y}) && (line_ext <= obj_top_ext);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_n            = state;
        line_n             = line;
        obj_n              = obj;
        index_n            = index;
        settled_n          = settled;
        busy_n             = busy;
        done_n             = done;
        scan_clear_start_o = 1'b0;
        scan_load_start_o  = 1'b0;

        unique case (state)
            IDLE: ;
            CLEAR_REQ: begin
                scan_clear_start_o = scan_ready_i;
                if (scan_ready_i) begin
                    state_n   = CLEAR_WAIT;
                    settled_n = 1'b0;
                end
            end
            CLEAR_WAIT: begin
                // Ready is still stale in the first cycle after the request.
                settled_n = 1'b1;
                if (settled && scan_ready_i) state_n = SCAN;
            end
            SCAN: begin
                if (hit) begin
                    obj_n   = obm_object_i;
                    state_n = LOAD_REQ;
                end else if (index == 6'd0) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    index_n = index - 6'd1;
                end
            end
            LOAD_REQ: begin
                scan_load_start_o = scan_ready_i;
                if (scan_ready_i) state_n = LOAD_WAIT;
            end
            LOAD_WAIT: begin
                if (scan_ready_i) begin
                    if (index == 6'd0) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        index_n = index - 6'd1;
                        state_n = SCAN;
                    end
                end
            end
            DONE: ;
            default: state_n = IDLE;
        endcase

        // A new request overrides whatever the walk was doing.
        if (start_i) begin
            line_n  = y_i;
            index_n = 6'd63;
            state_n = CLEAR_REQ;
            busy_n  = 1'b1;
            done_n  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge gpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            line    <= '0;
            obj     <= '0;
            index   <= '0;
            settled <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            line    <= line_n;
            obj     <= obj_n;
            index   <= index_n;
            settled <= settled_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    assign busy_o                = busy;
    assign done_o                = done;
    assign obm_index_o           = index;
    assign scan_new_y_o          = line;
    assign scan_load_object_o    = obj;
    assign pmf_object_o          = obj;
    assign pmf_intx_o            = scan_load_intx_i;
    assign pmf_inty_o            = scan_load_inty_i;
    assign scan_load_lightness_o = pmf_lightness_i;

endmodule

// File: tb/tb_object_scanline_loader.sv
module tb_object_scanline_loader;
    import obm_pkg::*;

    logic        gpu_clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [7:0]  y_i;
    logic        busy_o, done_o;
    logic [5:0]  obm_index_o;
    obm_object_t obm_object_i;
    logic        scan_ready_i;
    logic        scan_clear_start_o;
    logic [7:0]  scan_new_y_o;
    logic        scan_load_start_o;
    obm_object_t scan_load_object_o;
    logic [2:0]  scan_load_intx_i, scan_load_inty_i;
    obm_object_t pmf_object_o;
    logic [2:0]  pmf_intx_o, pmf_inty_o;
    logic [1:0]  pmf_lightness_i;
    logic [1:0]  scan_load_lightness_o;

    always #5 gpu_clk = ~gpu_clk;

    object_scanline_loader dut (
        .gpu_clk(gpu_clk), .rst_n(rst_n), .start_i(start_i), .y_i(y_i),
        .busy_o(busy_o), .done_o(done_o), .obm_index_o(obm_index_o),
        .obm_object_i(obm_object_i), .scan_ready_i(scan_ready_i),
        .scan_clear_start_o(scan_clear_start_o), .scan_new_y_o(scan_new_y_o),
        .scan_load_start_o(scan_load_start_o), .scan_load_object_o(scan_load_object_o),
        .scan_load_intx_i(scan_load_intx_i), .scan_load_inty_i(scan_load_inty_i),
        .pmf_object_o(pmf_object_o), .pmf_intx_o(pmf_intx_o), .pmf_inty_o(pmf_inty_o),
        .pmf_lightness_i(pmf_lightness_i), .scan_load_lightness_o(scan_load_lightness_o)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- environment: OBM, pattern memory, scanline buffer ----
    obm_object_t obm [64];
    assign obm_object_i = obm[obm_index_o];

    // pattern 0: solid; pattern 1: transparent column at intx 2; others hashed
    function automatic logic [1:0] pat_light(input obm_object_t o, input int ix, input int iy);
        if (o.pattern == 6'd0) return 2'd3;
        if (o.pattern == 6'd1) return (ix == 2) ? 2'd0 : 2'd3;
        return 2'((int'(o.pattern) + ix * 3 + iy * 5) % 4);
    endfunction

    assign pmf_lightness_i = pat_light(pmf_object_o, int'(pmf_intx_o), int'(pmf_inty_o));

    typedef enum {B_IDLE, B_CLEAR, B_LOAD} bstate_t;
    bstate_t     bstate = B_IDLE;
    int          bcnt = 0;
    int          blen = 0;
    obm_object_t bobj = '0;
    logic [7:0]  bline = '0;
    logic [1:0]  pix [256];
    logic [7:0]  inty_diff;

    assign scan_ready_i     = (bstate == B_IDLE);
    assign inty_diff        = bline - bobj.y;
    assign scan_load_intx_i = 3'(bcnt);
    assign scan_load_inty_i = inty_diff[2:0];

    always @(posedge gpu_clk) begin
        case (bstate)
            B_IDLE: begin
                if (scan_clear_start_o) begin
                    bstate <= B_CLEAR;
                    bcnt   <= 0;
                end else if (scan_load_start_o) begin
                    bstate <= B_LOAD;
                    bcnt   <= 0;
                    bobj   <= scan_load_object_o;
                    bline  <= scan_new_y_o;
                    blen   <= (256 - int'(scan_load_object_o.x) < 8) ? 256 - int'(scan_load_object_o.x) : 8;
                end
            end
            B_CLEAR: begin
                pix[bcnt] <= 2'd0;
                if (bcnt == 255) bstate <= B_IDLE;
                else bcnt <= bcnt + 1;
            end
            B_LOAD: begin
                if (scan_load_lightness_o != 2'd0) pix[int'(bobj.x) + bcnt] <= bobj.color;
                if (bcnt == blen - 1) bstate <= B_IDLE;
                else bcnt <= bcnt + 1;
            end
            default: bstate <= B_IDLE;
        endcase
    end

    // ---------------- cycle counter and protocol monitor -------------------
    int cyc = 0;
    always @(posedge gpu_clk) cyc <= cyc + 1;

    int mon_err = 0;
    int n_clear = 0;
    int clear_cyc = 0;
    int load_log [$];

    always @(negedge gpu_clk) begin
        if (scan_load_lightness_o !== pmf_lightness_i) begin
            mon_err <= mon_err + 1;
            if (mon_err < 5) $display("FAIL lightness relay: got %0d expected %0d", scan_load_lightness_o, pmf_lightness_i);
        end
        if (pmf_intx_o !== scan_load_intx_i || pmf_inty_o !== scan_load_inty_i) begin
            mon_err <= mon_err + 1;
            if (mon_err < 5) $display("FAIL pmf coords: got %0d/%0d expected %0d/%0d", pmf_intx_o, pmf_inty_o, scan_load_intx_i, scan_load_inty_i);
        end
        if (pmf_object_o !== scan_load_object_o) begin
            mon_err <= mon_err + 1;
            if (mon_err < 5) $display("FAIL pmf object: got %h expected %h", pmf_object_o, scan_load_object_o);
        end
        if (scan_clear_start_o && scan_load_start_o) begin
            mon_err <= mon_err + 1;
            if (mon_err < 5) $display("FAIL start overlap: got both starts expected at most one");
        end
        if ((scan_clear_start_o || scan_load_start_o) && !scan_ready_i) begin
            mon_err <= mon_err + 1;
            if (mon_err < 5) $display("FAIL start while busy: got start=1 expected 0 (ready=0)");
        end
        if (bstate == B_LOAD && scan_load_object_o !== bobj) begin
            mon_err <= mon_err + 1;
            if (mon_err < 5) $display("FAIL object stability: got %h expected %h", scan_load_object_o, bobj);
        end
        if (scan_clear_start_o) begin
            n_clear   <= n_clear + 1;
            clear_cyc <= cyc;
        end
        if (scan_load_start_o) load_log.push_back(int'(obm_index_o));
    end

    // ---------------- reference model ---------------------------------------
    int         ref_order [$];
    logic [1:0] ref_pix [256];
    int         ref_done;

    task automatic run_ref(input logic [7:0] line);
        ref_order.delete();
        for (int p = 0; p < 256; p++) ref_pix[p] = 2'd0;
        ref_done = 259;
        for (int i = 63; i >= 0; i--) begin
            int top = int'(obm[i].y) + 7;
            if (int'(line) >= int'(obm[i].y) && int'(line) <= top) begin
                int len = (256 - int'(obm[i].x) < 8) ? 256 - int'(obm[i].x) : 8;
                ref_order.push_back(i);
                ref_done += 3 + len;
                for (int k = 0; k < len; k++)
                    if (pat_light(obm[i], k, int'(line) - int'(obm[i].y)) != 2'd0)
                        ref_pix[int'(obm[i].x) + k] = obm[i].color;
            end else begin
                ref_done += 1;
            end
        end
    endtask

    // ---------------- line run and comparison helpers -----------------------
    int got_order [$];
    int got_done, got_clears, got_clear_cyc;

    task automatic run_line(input logic [7:0] line);
        int base_log, base_clr, t0;
        base_log = load_log.size();
        base_clr = n_clear;
        @(negedge gpu_clk);
        start_i = 1'b1;
        y_i     = line;
        t0      = cyc;
        @(negedge gpu_clk);
        start_i = 1'b0;
        while (!done_o && (cyc - t0) < 3000) @(negedge gpu_clk);
        got_done      = done_o ? cyc - t0 : -1;
        got_clears    = n_clear - base_clr;
        got_clear_cyc = clear_cyc - t0;
        got_order.delete();
        for (int i = base_log; i < load_log.size(); i++) got_order.push_back(load_log[i]);
    endtask

    task automatic compare_to_ref(input string tag);
        int nbad, first;
        check({tag, " load count"}, got_order.size(), ref_order.size());
        for (int i = 0; i < got_order.size() && i < ref_order.size(); i++)
            check({tag, " load order"}, got_order[i], ref_order[i]);
        nbad = 0;
        first = -1;
        for (int p = 0; p < 256; p++)
            if (pix[p] !== ref_pix[p]) begin
                nbad++;
                if (first < 0) first = p;
            end
        if (first >= 0) $display("first differing pixel %0d: got %0d want %0d", first, pix[first], ref_pix[first]);
        check({tag, " pixel diffs"}, nbad, 0);
    endtask

    task automatic setup_obm(input int s);
        for (int i = 0; i < 64; i++) obm[i] = '{y: 8'd240, x: 8'd0, pattern: 6'd0, color: 2'd0};
        case (s)
            1: begin
                obm[5]  = '{y: 8'd8, x: 8'd20, pattern: 6'd0, color: 2'd3};
                obm[60] = '{y: 8'd8, x: 8'd20, pattern: 6'd0, color: 2'd1};
            end
            2: obm[7]  = '{y: 8'd252, x: 8'd100, pattern: 6'd0, color: 2'd2};
            3: obm[30] = '{y: 8'd3,   x: 8'd40,  pattern: 6'd0, color: 2'd1};
            4: obm[9]  = '{y: 8'd50,  x: 8'd252, pattern: 6'd0, color: 2'd3};
            5: begin
                obm[3] = '{y: 8'd20, x: 8'd100, pattern: 6'd0, color: 2'd1};
                obm[2] = '{y: 8'd20, x: 8'd100, pattern: 6'd1, color: 2'd2};
            end
            default: ;
        endcase
    endtask

    typedef struct {
        int         setup;
        logic [7:0] line;
        int         exp_loads;
        int         exp_done;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        bit seen;
        // setup, line, loads, done cycle (259 + misses + sum(3 + load length))
        vecs[0] = '{0, 8'd10,  0, 323};
        vecs[1] = '{1, 8'd12,  2, 343};
        vecs[2] = '{2, 8'd2,   0, 323};
        vecs[3] = '{3, 8'd3,   1, 333};
        vecs[4] = '{3, 8'd10,  1, 333};
        vecs[5] = '{3, 8'd11,  0, 323};
        vecs[6] = '{4, 8'd55,  1, 329};
        vecs[7] = '{5, 8'd21,  2, 343};

        rst_n   = 1'b0;
        start_i = 1'b0;
        y_i     = 8'd0;
        setup_obm(0);
        repeat (3) @(negedge gpu_clk);
        check("reset busy", int'(busy_o), 0);
        check("reset done", int'(done_o), 0);
        check("reset clear start", int'(scan_clear_start_o), 0);
        check("reset load start", int'(scan_load_start_o), 0);
        check("reset index", int'(obm_index_o), 0);
        check("reset new_y", int'(scan_new_y_o), 0);
        check("reset object", int'(scan_load_object_o), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge gpu_clk);
        check("idle no clear", n_clear, 0);

        // ---- directed table ----
        foreach (vecs[v]) begin
            setup_obm(vecs[v].setup);
            run_ref(vecs[v].line);
            run_line(vecs[v].line);
            check($sformatf("vec%0d done cycle", v), got_done, vecs[v].exp_done);
            check($sformatf("vec%0d loads", v), got_order.size(), vecs[v].exp_loads);
            check($sformatf("vec%0d clear pulses", v), got_clears, 1);
            check($sformatf("vec%0d clear cycle", v), got_clear_cyc, 1);
            check($sformatf("vec%0d busy after done", v), int'(busy_o), 0);
            compare_to_ref($sformatf("vec%0d", v));
        end

        // ---- randomized lines against the reference model ----
        for (int r = 0; r < 12; r++) begin
            logic [7:0] line;
            line = 8'($urandom_range(0, 255));
            for (int i = 0; i < 64; i++) begin
                obm[i].x       = 8'($urandom_range(0, 255));
                obm[i].pattern = 6'($urandom_range(0, 63));
                obm[i].color   = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) obm[i].y = line - 8'($urandom_range(0, 9));
                else obm[i].y = 8'($urandom_range(0, 255));
            end
            run_ref(line);
            run_line(line);
            check($sformatf("rand%0d done cycle", r), got_done, ref_done);
            compare_to_ref($sformatf("rand%0d", r));
        end

        // ---- restart mid-load, then reset mid-clear ----
        setup_obm(1);
        @(negedge gpu_clk);
        start_i = 1'b1;
        y_i     = 8'd12;
        @(negedge gpu_clk);
        start_i = 1'b0;
        c0 = 0;
        while (bstate != B_LOAD && c0 < 1000) begin
            @(negedge gpu_clk);
            c0++;
        end
        check("reach load", int'(bstate == B_LOAD), 1);
        start_i = 1'b1;
        y_i     = 8'd77;
        c0      = n_clear;
        @(negedge gpu_clk);
        start_i = 1'b0;
        check("restart holds clear", int'(scan_clear_start_o), 0);
        check("restart new_y", int'(scan_new_y_o), 77);
        check("restart busy", int'(busy_o), 1);
        check("restart done", int'(done_o), 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge gpu_clk);
            if (scan_clear_start_o) seen = 1;
        end
        check("restart clear after load", int'(seen), 1);
        repeat (4) @(negedge gpu_clk);
        check("buffer clearing", int'(bstate == B_CLEAR), 1);
        rst_n = 1'b0;
        #1;
        check("midreset busy", int'(busy_o), 0);
        check("midreset done", int'(done_o), 0);
        check("midreset index", int'(obm_index_o), 0);
        check("midreset new_y", int'(scan_new_y_o), 0);
        check("midreset object", int'(scan_load_object_o), 0);
        check("midreset load start", int'(scan_load_start_o), 0);
        @(negedge gpu_clk);
        rst_n = 1'b1;
        c0 = n_clear;
        repeat (300) @(negedge gpu_clk);
        check("post reset idle clears", n_clear - c0, 0);
        check("post reset done", int'(done_o), 0);

        // a fresh build after the interrupted one still produces the right line
        run_ref(8'd12);
        run_line(8'd12);
        check("rebuild done cycle", got_done, ref_done);
        check("rebuild new_y", int'(scan_new_y_o), 12);
        compare_to_ref("rebuild");

        check("monitor errors", mon_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
